regfile_port_arbiter: RTL

Shares the 16×8 register file's write port and read port 1 between the core (controller-driven datapath writeback and operand reads) and a host/debug requester. Core traffic always wins; one host operation is buffered until its port is free, with an optional starvation guard that briefly stalls the core. Sits between `controller_fsm`/accumulator writeback and `register_file`.

---
 rtl/regfile_port_arbiter.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter
//
// Shares the register file's write port and read port 1 between the core
// (controller writeback and operand reads) and a host/debug requester.
// The core always has priority. One host operation is buffered and issued
// on the first cycle its port is free. Core and host can use different
// ports in the same cycle, for example a core write together with a host read.
//
// Optional feature, selected by the macro REGARB_STARVE_GUARD_EN:
//   defined     - starve counter and FORCE state are present. After
//                 STARVE_LIMIT blocked PEND cycles, the core is stalled for
//                 one cycle and the buffered host operation takes its port.
//   not defined - strict core priority. core_stall is always 0.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   core_we/waddr/wdata   core write request
//   core_rd1_use/raddr1   core read-port-1 request
//   core_stall        core request this cycle was not performed; the core must repeat it
//   host_req/we/addr/wdata  host operation request (accepted when host_ready=1)
//   host_ready        arbiter can accept a host request
//   host_done         one-cycle pulse: host write committed
//   host_rvalid       one-cycle pulse: host_rdata holds a new read result
//   host_rdata        last host read result
//   write_enable/address/data   register file write port
//   read_address1 / read_data1  register file read port 1 (combinational read)

module regfile_port_arbiter #(
  parameter int WORD_SIZE    = 8,
  parameter int INDEX_SIZE   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  core_we,
  input  logic [INDEX_SIZE-1:0] core_waddr,
  input  logic [WORD_SIZE-1:0]  core_wdata,
  input  logic                  core_rd1_use,
  input  logic [INDEX_SIZE-1:0] core_raddr1,
  output logic                  core_stall,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [INDEX_SIZE-1:0] host_addr,
  input  logic [WORD_SIZE-1:0]  host_wdata,
  output logic                  host_ready,
  output logic                  host_done,
  output logic                  host_rvalid,
  output logic [WORD_SIZE-1:0]  host_rdata,
  output logic                  write_enable,
  output logic [INDEX_SIZE-1:0] write_address,
  output logic [WORD_SIZE-1:0]  write_data,
  output logic [INDEX_SIZE-1:0] read_address1,
  input  logic [WORD_SIZE-1:0]  read_data1
);

`ifdef REGARB_STARVE_GUARD_EN
  typedef enum logic [1:0] {IDLE = 2'd0, PEND = 2'd1, FORCE = 2'd2} state_t;
  // The counter value in the last blocked PEND cycle before FORCE.
  localparam logic [7:0] CNT_LAST = 8'(STARVE_LIMIT - 1);
`else
  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;
`endif

  state_t state_q, state_d;

  // Buffered host operation
  logic                  buf_we_q;
  logic [INDEX_SIZE-1:0] buf_addr_q;
  logic [WORD_SIZE-1:0]  buf_wdata_q;

  // Host completion signals, registered one cycle after issue
  logic                  done_p1;
  logic                  rvalid_p1;
  logic [WORD_SIZE-1:0]  rdata_p1;

  logic accept;
  logic issue;
  logic forced;
  logic issue_wr;
  logic issue_rd;
  logic port_free;

`ifdef REGARB_STARVE_GUARD_EN
  logic [7:0] cnt_q;
`endif

  // The buffered operation needs only the port matching its direction.
  assign port_free = buf_we_q ? !core_we : !core_rd1_use;

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    issue      = 1'b0;
    forced     = 1'b0;
    host_ready = 1'b0;
    case (state_q)
      IDLE: begin
        host_ready = 1'b1;
        if (host_req) begin
          accept  = 1'b1;
          state_d = PEND;
        end
      end
      PEND: begin
        if (port_free) begin
          issue   = 1'b1;
          state_d = IDLE;
        end
`ifdef REGARB_STARVE_GUARD_EN
        else if (cnt_q == CNT_LAST) begin
          state_d = FORCE;
        end
`endif
      end
`ifdef REGARB_STARVE_GUARD_EN
      FORCE: begin
        forced  = 1'b1;
        issue   = 1'b1;
        state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
    // While reset is asserted, nothing is accepted or issued. This keeps the
    // register file from being written by a buffered operation that will be dropped.
    if (rst) begin
      host_ready = 1'b0;
      accept     = 1'b0;
      issue      = 1'b0;
      forced     = 1'b0;
    end
  end

  assign issue_wr = issue &  buf_we_q;
  assign issue_rd = issue & ~buf_we_q;

  // Port muxing. A forced slot suppresses the core write, even when the
  // host operation is a read, because the core repeats the whole stalled request.
  assign write_enable  = issue_wr | (core_we & ~forced & ~rst);
  assign write_address = issue_wr ? buf_addr_q  : core_waddr;
  assign write_data    = issue_wr ? buf_wdata_q : core_wdata;
  assign read_address1 = issue_rd ? buf_addr_q  : core_raddr1;
  assign core_stall    = forced;

  assign host_done   = done_p1;
  assign host_rvalid = rvalid_p1;
  assign host_rdata  = rdata_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      buf_we_q    <= 1'b0;
      buf_addr_q  <= '0;
      buf_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        buf_we_q    <= host_we;
        buf_addr_q  <= host_addr;
        buf_wdata_q <= host_wdata;
      end
    end
  end

  // ---- stage p1: host completion, one cycle after issue ----
  // read_data1 is sampled on the issue edge. A core write in that same
  // cycle lands on the same edge, so the read returns the pre-write value.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_p1   <= 1'b0;
      rvalid_p1 <= 1'b0;
      rdata_p1  <= '0;
    end else begin
      done_p1   <= issue_wr;
      rvalid_p1 <= issue_rd;
      if (issue_rd) begin
        rdata_p1 <= read_data1;
      end
    end
  end

`ifdef REGARB_STARVE_GUARD_EN
  // Counts blocked PEND cycles since the operation was accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
    end else if (state_q == PEND && !issue) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end
`endif

endmodule
